data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 7 +
 rtl/dmr_mem_array.sv | 18 +
 rtl/data_mem_responder.sv | 77 +++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared state encoding and default sizing for the memory responder
package data_mem_responder_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_LATENCY = 2;
    localparam int WORD_W      = 32;
endpackage

// File: rtl/dmr_mem_array.sv
// dmr_mem_array: word storage with synchronous write and combinational read
module dmr_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);
    logic [WORD_W-1:0] r_mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding memory responder with fixed access latency and address checking
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);
    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic              r_we, r_err;
    logic [WORD_W-1:0] r_addr, r_wdata, r_rdata;
    logic              w_err, w_access, w_mem_we;
    logic [WORD_W-1:0] w_mem_rdata;

    assign w_err    = (|r_addr[1:0]) | (|r_addr[WORD_W-1:ADDR_W+2]);
    assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
    // A reset landing on the access edge must not commit the pending write
    assign w_mem_we = w_access && r_we && !w_err && rst_n;

    dmr_mem_array #(.ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (r_addr[ADDR_W+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE && req_valid)  ? BUSY :
                 w_access                        ? RESP :
                 (r_state == RESP && resp_ready) ? IDLE : r_state;
    end

    always_comb begin
        req_ready  = (r_state == IDLE);
        resp_valid = (r_state == RESP);
        resp_rdata = r_rdata;
        resp_err   = r_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= 4'(LATENCY - 1);
            end
            if (r_state == BUSY && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (w_access) begin
                r_rdata <= (r_we || w_err) ? '0 : w_mem_rdata;
                r_err   <= w_err;
            end
        end
    end
endmodule
